display_refresh_scanner: RTL
============================

Name: display_refresh_scanner

Overview:
Upstream stage of the anode decoder in the calculator's 7-segment display path. Divides the system clock into a per-digit refresh tick and drives the 2-bit refreshcounter that the anode decoder consumes. Double-buffers the 4-digit BCD result from the calculator core so a new value only takes effect at a frame boundary. Presents the selected digit nibble plus a leading-zero blank flag to the segment decoder, aligned with refreshcounter.

Parameters:
CLK_DIV, 100000, clk cycles per digit slot (1 kHz digit rate / 250 Hz frame at 100 MHz); legal range >= 2
NUM_DIGITS, 4, digits per frame; fixed at 4, taken from package

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
value_in  input  16  four BCD nibbles; [15:12] = digit 3 (most significant), [3:0] = digit 0
value_valid  input  1  one-cycle strobe; captures value_in
blank_lz  input  1  enables leading-zero blanking; sampled every cycle
refreshcounter  output  2  active digit index 0..3; feeds the anode decoder
digit_out  output  4  nibble of the active register at index refreshcounter
digit_blank  output  1  1 = segment decoder drives all segments off for this slot
value_ack  output  1  one-cycle pulse when a value moves into the active register
frame_done  output  1  one-cycle pulse on every refreshcounter 3->0 transition

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: prescaler 0, refreshcounter 0, active register 16'h0000, pending register 16'h0000, pending flag 0, value_ack 0, frame_done 0. digit_out = 0 and digit_blank = 0 follow from these.
- Prescaler: counts 0..CLK_DIV-1 and wraps to 0. tick = (count == CLK_DIV-1).
- refreshcounter: increments by 1 on tick and wraps 3->0. The first increment occurs CLK_DIV cycles after reset deasserts.
- Frame boundary: the cycle where tick=1 and refreshcounter=3. frame_done=1 in the following cycle, coincident with refreshcounter=0.
- Capture: value_valid=1 writes value_in to pending and sets the pending flag. A later strobe before the boundary overwrites pending: latest value wins, and only one ack is issued.
- Load on a boundary cycle:
  - If value_valid=1 in the boundary cycle, active <= value_in and pending is cleared.
  - Otherwise, if the pending flag is set, active <= pending and the flag is cleared.
  - In either case value_ack pulses one cycle, coincident with frame_done.
  - No load occurs and no ack is issued when nothing is pending.
- Outputs: digit_out and digit_blank are combinational from registered state (active, refreshcounter, blank_lz). Zero latency relative to refreshcounter, so anode and segments switch in the same cycle.
- Blanking: digit i is blanked iff blank_lz=1, i != 0, and nibbles 3 down to i are all 4'h0. Digit 0 is never blanked.
- Non-BCD nibbles (A-F) pass through unchanged and count as nonzero.
- Reset mid-frame: discards any pending value; no ack pulse is issued.

Decomposition:
- Package display_pkg holds:
  - NUM_DIGITS = 4, DIGIT_W = 4, IDX_W = 2
  - a digit-index typedef
  - constant BLANK_NONE
- Sub-module refresh_prescaler (parameter CLK_DIV; ports clk, reset, tick) holds the divider. The scanner holds the index, the buffering and the blank logic.

Test Plan:
1. Reset, CLK_DIV=4 -> refreshcounter=0, digit_out=0, digit_blank=0; refreshcounter becomes 1 exactly 4 cycles after reset drops.
2. Free run 20 cycles -> refreshcounter sequence 0,1,2,3,0 with each value held 4 cycles; frame_done high only in the cycle refreshcounter returns to 0.
3. value_valid with 16'h1234 while refreshcounter=1 -> digit_out stays 0 until the boundary; value_ack pulses with frame_done; then digit_out = 4,3,2,1 for refreshcounter 0,1,2,3.
4. Strobes 16'h1111 then 16'h2222 within one frame -> a single value_ack; display shows 2222; 1111 never appears.
5. Blanking:
   - blank_lz=1, value 16'h0045 -> digit_blank=1 at refreshcounter 3 and 2; 0 at 1 and 0.
   - Value 16'h0000 -> blank at 3, 2, 1; digit 0 shows 0 unblanked.
   - blank_lz=0 -> no blanking.
6. Strobe 16'h9999, then reset asserted before the boundary -> after reset, active=0, no value_ack at the next frame boundary, display shows 0000.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and helpers for the 7-segment refresh path.
package display_pkg;
   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int IDX_W      = 2;

   typedef logic [IDX_W-1:0] digit_idx_t;

   localparam logic [NUM_DIGITS-1:0] BLANK_NONE = '0;

   // Bit i set when digit i is a leading zero (nibbles NUM_DIGITS-1 down to i all zero).
   // Digit 0 is always kept so a zero value still shows one digit.
   function automatic logic [NUM_DIGITS-1:0] lz_mask(input logic [NUM_DIGITS*DIGIT_W-1:0] v);
      logic [NUM_DIGITS-1:0] m;
      logic                  all_zero;
      m        = BLANK_NONE;
      all_zero = 1'b1;
      for (int i = NUM_DIGITS-1; i > 0; i--) begin
         all_zero = all_zero & (v[i*DIGIT_W +: DIGIT_W] == '0);
         m[i]     = all_zero;
      end
      return m;
   endfunction
endpackage

// File: rtl/refresh_prescaler.sv
// Divides clk down to a one-cycle tick every CLK_DIV cycles.
module refresh_prescaler #(
   parameter int CLK_DIV = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);
   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] count;

   assign tick = (count == CW'(CLK_DIV-1));

   always_ff @(posedge clk) begin
      if (reset)     count <= '0;
      else if (tick) count <= '0;
      else           count <= count + 1'b1;
   end
endmodule

// File: rtl/display_refresh_scanner.sv
// Digit scanner: refresh index, frame-aligned double buffer and leading-zero blanking.
module display_refresh_scanner
   import display_pkg::*;
#(
   parameter int CLK_DIV = 100000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_DIGITS*DIGIT_W-1:0] value_in,
   input  logic                          value_valid,
   input  logic                          blank_lz,
   output logic [IDX_W-1:0]              refreshcounter,
   output logic [DIGIT_W-1:0]            digit_out,
   output logic                          digit_blank,
   output logic                          value_ack,
   output logic                          frame_done
);
   logic                                    tick;
   logic                                    boundary;
   digit_idx_t                              idx;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      active;
   logic [NUM_DIGITS-1:0][DIGIT_W-1:0]      pending;
   logic                                    pend_flag;
   logic [NUM_DIGITS-1:0]                   mask;

   refresh_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign boundary = tick && (idx == digit_idx_t'(NUM_DIGITS-1));

   always_ff @(posedge clk) begin
      if (reset) idx <= '0;
      else if (tick) idx <= idx + 1'b1;
   end

   // A strobe in the boundary cycle bypasses pending and goes straight to active.
   always_ff @(posedge clk) begin
      if (reset) begin
         active     <= '0;
         pending    <= '0;
         pend_flag  <= 1'b0;
         value_ack  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= boundary;
         value_ack  <= 1'b0;
         if (boundary) begin
            if (value_valid) begin
               active    <= value_in;
               pend_flag <= 1'b0;
               value_ack <= 1'b1;
            end else if (pend_flag) begin
               active    <= pending;
               pend_flag <= 1'b0;
               value_ack <= 1'b1;
            end
         end else if (value_valid) begin
            pending   <= value_in;
            pend_flag <= 1'b1;
         end
      end
   end

   assign mask           = lz_mask(active);
   assign refreshcounter = idx;
   assign digit_out      = active[idx];
   assign digit_blank    = blank_lz & mask[idx];
endmodule
